// File: rtl/rand_walk.sv
// Bounded random walk: integrates a signed step word every TICK_DIV+1 clocks,
// saturating at [POS_MIN, POS_MAX], with a four-phase snapshot port for the CPU.
module rand_walk #(
  parameter int WIDTH      = 32,
  parameter int TICK_DIV   = 1000,
  parameter int POS_MIN    = -100,
  parameter int POS_MAX    = 100,
  parameter int POS_INIT   = 0,
  parameter int STEP_SHIFT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] step_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pos,
  output logic             step_tick,
  output logic             at_min,
  output logic             at_max,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data
);

  // state  | meaning
  // IDLE   | walk stopped, cnt held at 0
  // COUNT  | counting TICK_DIV clocks toward the next step
  // UPDATE | one cycle; step applied on the exit edge
  typedef enum logic [1:0] {IDLE, COUNT, UPDATE} state_t;

  localparam int SW = WIDTH + STEP_SHIFT + 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [SW-1:0] MIN_S = SW'(POS_MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(POS_MAX);
  localparam logic [WIDTH-1:0] MIN_P  = WIDTH'(POS_MIN);
  localparam logic [WIDTH-1:0] MAX_P  = WIDTH'(POS_MAX);
  localparam logic [WIDTH-1:0] INIT_P = WIDTH'(POS_INIT);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [WIDTH-1:0]  pos_nx;
  logic              tick_nx;
  logic signed [SW-1:0] sum, load_ext;

  function automatic logic [WIDTH-1:0] clamp(input logic signed [SW-1:0] x);
    if (x < MIN_S)      return MIN_P;
    else if (x > MAX_S) return MAX_P;
    else                return WIDTH'(x);
  endfunction

  // Widened arithmetic so even extreme steps cannot wrap before clamping.
  always_comb begin
    sum      = SW'($signed(pos)) + (SW'($signed(step_in)) <<< STEP_SHIFT);
    load_ext = SW'($signed(load_val));
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pos_nx   = pos;
    tick_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (enable) state_nx = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = UPDATE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      UPDATE: begin
        pos_nx   = clamp(sum);
        tick_nx  = 1'b1;
        cnt_nx   = '0;
        state_nx = enable ? COUNT : IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    // A load discards any step landing on the same edge.
    if (load) begin
      pos_nx   = clamp(load_ext);
      cnt_nx   = '0;
      tick_nx  = 1'b0;
      state_nx = enable ? COUNT : IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pos       <= INIT_P;
      step_tick <= 1'b0;
      at_min    <= (INIT_P == MIN_P);
      at_max    <= (INIT_P == MAX_P);
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pos       <= pos_nx;
      step_tick <= tick_nx;
      at_min    <= (pos_nx == MIN_P);
      at_max    <= (pos_nx == MAX_P);
    end
  end

  // Snapshot captures the pre-edge position, independent of the walk state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else if (rd_req && !rd_ack) begin
      rd_ack  <= 1'b1;
      rd_data <= pos;
    end else if (!rd_req && rd_ack) begin
      rd_ack  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rand_walk.sv
// Directed self-checking bench for rand_walk with TICK_DIV=4 and default bounds.
module tb_rand_walk;
  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] step_in;
  logic        load;
  logic [31:0] load_val;
  logic [31:0] pos;
  logic        step_tick;
  logic        at_min;
  logic        at_max;
  logic        rd_req;
  logic        rd_ack;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;
  int seen_tick;

  rand_walk #(
    .WIDTH(32), .TICK_DIV(4), .POS_MIN(-100), .POS_MAX(100),
    .POS_INIT(0), .STEP_SHIFT(0)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .step_in(step_in),
    .load(load), .load_val(load_val), .pos(pos), .step_tick(step_tick),
    .at_min(at_min), .at_max(at_max), .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_data(rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; step_in = '0; load = 1'b0;
    load_val = '0; rd_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_pos", pos, 32'd0);
    check("rst_at_min", {31'd0, at_min}, 32'd0);
    check("rst_at_max", {31'd0, at_max}, 32'd0);
    check("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_tick", {31'd0, step_tick}, 32'd0);

    // first step lands TICK_DIV+1 edges after enable is sampled
    enable = 1'b1; step_in = 32'd3;
    tick(1);
    tick(4);
    check("lat_pos_before", pos, 32'd0);
    check("lat_tick_before", {31'd0, step_tick}, 32'd0);
    tick(1);
    check("step1_pos", pos, 32'd3);
    check("step1_tick", {31'd0, step_tick}, 32'd1);
    tick(1);
    check("tick_one_cycle", {31'd0, step_tick}, 32'd0);
    tick(3);
    check("step2_pos_before", pos, 32'd3);
    tick(1);
    check("step2_pos", pos, 32'd6);
    check("step2_tick", {31'd0, step_tick}, 32'd1);

    // saturation at the upper bound
    load = 1'b1; load_val = 32'd98;
    tick(1);
    load = 1'b0;
    check("load98_pos", pos, 32'd98);
    step_in = 32'd5;
    tick(5);
    check("sat_max_pos", pos, 32'd100);
    check("sat_max_flag", {31'd0, at_max}, 32'd1);
    check("sat_max_tick", {31'd0, step_tick}, 32'd1);
    step_in = 32'hFFFF_FFF8;
    tick(5);
    check("down8_pos", pos, 32'd92);
    check("down8_at_max", {31'd0, at_max}, 32'd0);
    load = 1'b1; load_val = 32'hFFFF_FE0C;
    tick(1);
    load = 1'b0;
    check("load_m500_pos", pos, 32'hFFFF_FF9C);
    check("load_m500_at_min", {31'd0, at_min}, 32'd1);

    // extreme steps must not wrap
    load = 1'b1; load_val = 32'd0;
    tick(1);
    load = 1'b0;
    check("load0_at_min", {31'd0, at_min}, 32'd0);
    step_in = 32'h7FFF_FFFF;
    tick(5);
    check("ext_pos_max", pos, 32'd100);
    check("ext_at_max", {31'd0, at_max}, 32'd1);
    step_in = 32'h8000_0000;
    tick(5);
    check("ext_pos_min", pos, 32'hFFFF_FF9C);
    check("ext_at_min", {31'd0, at_min}, 32'd1);
    check("ext_at_max_clr", {31'd0, at_max}, 32'd0);

    // load wins over the UPDATE exit edge
    tick(4);
    load = 1'b1; load_val = 32'd7; step_in = 32'd2;
    tick(1);
    load = 1'b0;
    check("prio_pos", pos, 32'd7);
    check("prio_tick", {31'd0, step_tick}, 32'd0);
    tick(4);
    check("prio_next_before", pos, 32'd7);
    tick(1);
    check("prio_next_pos", pos, 32'd9);
    check("prio_next_tick", {31'd0, step_tick}, 32'd1);

    // enable drop mid-count cancels the pending step
    tick(2);
    enable = 1'b0;
    seen_tick = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (step_tick) seen_tick++;
    end
    check("drop_pos", pos, 32'd9);
    check("drop_no_tick", 32'(seen_tick), 32'd0);
    enable = 1'b1;
    tick(1);
    tick(4);
    check("reen_before", pos, 32'd9);
    tick(1);
    check("reen_pos", pos, 32'd11);

    // snapshot handshake around update edges
    load = 1'b1; load_val = 32'd42;
    tick(1);
    load = 1'b0;
    step_in = 32'd3;
    tick(4);
    rd_req = 1'b1;
    tick(1);
    check("hs_pos", pos, 32'd45);
    check("hs_rd_data", rd_data, 32'd42);
    check("hs_rd_ack", {31'd0, rd_ack}, 32'd1);
    tick(3);
    check("hs_hold_data", rd_data, 32'd42);
    check("hs_hold_ack", {31'd0, rd_ack}, 32'd1);
    rd_req = 1'b0;
    tick(1);
    check("hs_release_ack", {31'd0, rd_ack}, 32'd0);
    rd_req = 1'b1;
    tick(1);
    check("hs2_rd_data", rd_data, 32'd45);
    check("hs2_pos", pos, 32'd48);
    check("hs2_rd_ack", {31'd0, rd_ack}, 32'd1);

    // asynchronous reset mid-handshake
    #2;
    reset = 1'b1;
    #1;
    check("async_rd_ack", {31'd0, rd_ack}, 32'd0);
    check("async_pos", pos, 32'd0);
    check("async_rd_data", rd_data, 32'd0);
    rd_req = 1'b0; enable = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    check("post_rst_pos", pos, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rand_walk.md
Name: rand_walk

Overview:
- Consumes the signed random step word produced by the LFSR random generator and integrates it into a bounded random-walk position.
- Typical use: jitter and motion of game objects.
- Applies one step every TICK_DIV+1 clocks while enabled, saturating at programmable bounds.
- Exposes the position directly, plus a four-phase request/acknowledge snapshot port for the CPU.

Parameters:
- WIDTH, 32: datapath width of step_in, pos, load_val and rd_data.
- TICK_DIV, 1000: counter cycles per step (legal range ≥1).
- POS_MIN, -100: lower saturation bound, signed.
- POS_MAX, 100: upper saturation bound, signed; POS_MIN < POS_MAX.
- POS_INIT, 0: reset position, signed; POS_MIN ≤ POS_INIT ≤ POS_MAX.
- STEP_SHIFT, 0: left-shift applied to step_in before accumulation (step gain).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  level; run the walk when high.
- step_in  input  WIDTH  signed two's-complement step from the random generator; sampled in UPDATE.
- load  input  1  single-cycle strobe; overwrite the position.
- load_val  input  WIDTH  signed value for load.
- pos  output  WIDTH  current signed position, registered.
- step_tick  output  1  one-cycle pulse; pos took a new stepped value this cycle.
- at_min  output  1  registered; pos == POS_MIN.
- at_max  output  1  registered; pos == POS_MAX.
- rd_req  input  1  CPU snapshot request, level.
- rd_ack  output  1  snapshot acknowledge, level.
- rd_data  output  WIDTH  snapshot of pos, held stable while rd_ack is high.

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- Reset values: pos=POS_INIT, state=IDLE, cnt=0, step_tick=0, rd_ack=0, rd_data=0. at_min and at_max reflect POS_INIT.
- State machine (IDLE, COUNT, UPDATE):
  - IDLE: cnt held at 0. enable=1 at an edge → COUNT.
  - COUNT: cnt increments each edge. At the edge where cnt==TICK_DIV-1: cnt←0, → UPDATE.
  - UPDATE: one cycle. At its exit edge pos←clamp(pos+(step_in<<<STEP_SHIFT)) and step_tick←1 for one cycle. Next state is COUNT if enable=1, else IDLE.
- Step period is TICK_DIV+1 clocks. First pos change occurs TICK_DIV+1 edges after the edge that sampled enable=1.
- enable=0 while in COUNT: → IDLE at the next edge, cnt←0, no step applied.
- enable=0 while in UPDATE: the step still completes, then → IDLE.
- Arithmetic:
  - Sum is computed signed in WIDTH+STEP_SHIFT+1 bits, so there is no wrap-around.
  - clamp(x) = POS_MIN if x<POS_MIN; POS_MAX if x>POS_MAX; otherwise x.
  - A step of 0 still pulses step_tick.
- Load:
  - load=1 at an edge: pos←clamp(load_val), cnt←0.
  - If in UPDATE, the step is discarded and step_tick stays 0.
  - State becomes COUNT if enable=1, else IDLE.
  - Load has priority over UPDATE on the same edge.
- at_min and at_max are updated on the same edge as pos. They are never both 1.
- Snapshot handshake, four-phase:
  - Edge with rd_req=1 and rd_ack=0: rd_data←pos (pre-edge value, i.e. excluding any update landing on the same edge), rd_ack←1.
  - While rd_req=1, rd_ack stays 1 and rd_data is frozen.
  - Edge with rd_req=0 and rd_ack=1: rd_ack←0.
  - A new capture requires rd_ack=0 first. The handshake runs independently of enable and state.
- Reset mid-operation (any state, mid-handshake) returns all registers immediately to their reset values. rd_ack drops asynchronously.

Test Plan:
- Reset, TICK_DIV=4, POS_INIT=0: pos=0, at_min=at_max=0, rd_ack=0. Then enable=1, step_in=3 → pos=3 with step_tick pulse exactly 5 edges after enable sampled; pos=6 after 5 more edges.
- Saturation, POS_MAX=100: load_val=98, step_in=5 → pos=100, at_max=1. Then step_in=-8 → pos=92, at_max=0. Load_val=-500 → pos=-100, at_min=1.
- Extreme input: step_in=32'h7FFFFFFF from pos=0 → pos=100, no wrap. Then step_in=32'h80000000 → pos=-100.
- Priority: load=1 with load_val=7 on the UPDATE exit edge, step_in=2 → pos=7, step_tick=0, next step lands 5 edges later.
- Enable drop: enable→0 at cnt=2 → IDLE, pos unchanged, no step_tick. Re-enable → full 5-edge latency again.
- Handshake: rd_req=1 while pos=42 on an update edge that makes pos=45 → rd_data=42, rd_ack=1 held. rd_req→0 → rd_ack=0 next edge. Assert reset while rd_ack=1 → rd_ack=0 and pos=POS_INIT immediately.
